// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller.
//
// Accepts one M-stage request at a time. It checks alignment, issues a single data-memory
// access, and stalls the pipeline for DM_LAT+1 cycles. Load data is lane-selected and
// sign- or zero-extended before it is returned.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid/we/size/addr/wdata   request from the M stage
//   stall, misalign        pipeline freeze and alignment-exception flag
//   dm_en/we/be/addr/wdata data-memory strobes and registered access fields
//   dm_rdata               data-memory read word
//   rd_valid, rd_data      load completion pulse and extended load result
module mem_access_ctrl #(
  parameter int unsigned DM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        misalign,
  output logic        dm_en,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [2:0] LatInit = 3'(DM_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        dm_en_q, dm_en_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        stall_c, misalign_c, rd_valid_c;

  // Request size decode; 101-111 alias to word.
  logic req_is_h, req_is_b, req_is_w, req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;

  always_comb begin
    req_is_h = (req_size == 3'b001) || (req_size == 3'b011);
    req_is_b = (req_size == 3'b010) || (req_size == 3'b100);
    req_is_w = !req_is_h && !req_is_b;

    req_misaligned = 1'b0;
    if (req_is_w)      req_misaligned = |req_addr[1:0];
    else if (req_is_h) req_misaligned = req_addr[0];

    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    if (req_is_h) begin
      req_wdata_rep = {2{req_wdata[15:0]}};
      if (req_we) req_be = req_addr[1] ? 4'b1100 : 4'b0011;
    end else if (req_is_b) begin
      req_wdata_rep = {4{req_wdata[7:0]}};
      if (req_we) req_be = 4'b0001 << req_addr[1:0];
    end
  end

  // Lane select and extension of the returned word for the latched request.
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] rd_ext;

  always_comb begin
    rd_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    unique case (off_q)
      2'd0:    rd_byte = dm_rdata[7:0];
      2'd1:    rd_byte = dm_rdata[15:8];
      2'd2:    rd_byte = dm_rdata[23:16];
      default: rd_byte = dm_rdata[31:24];
    endcase
    unique case (size_q)
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b011:  rd_ext = {16'h0000, rd_half};
      3'b010:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_ext = {24'h000000, rd_byte};
      default: rd_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    off_d      = off_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    dm_en_d    = 1'b0;
    dm_we_d    = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    rd_valid_c = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_misaligned) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = StWait;
            cnt_d   = LatInit;
            size_d  = req_size;
            off_d   = req_addr[1:0];
            we_d    = req_we;
            be_d    = req_be;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = req_wdata_rep;
            // Strobes are registered so they are high only in the first WAIT cycle.
            dm_en_d = 1'b1;
            dm_we_d = req_we;
          end
        end
      end
      StWait: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StDone;
          if (!we_q) rd_data_d = rd_ext;
        end
      end
      StDone: begin
        // Any req_valid here is the completing instruction itself, so it is ignored.
        rd_valid_c = !we_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      size_q    <= 3'd0;
      off_q     <= 2'd0;
      we_q      <= 1'b0;
      dm_en_q   <= 1'b0;
      dm_we_q   <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      off_q     <= off_d;
      we_q      <= we_d;
      dm_en_q   <= dm_en_d;
      dm_we_q   <= dm_we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Combinational outputs are gated so everything reads 0 while reset is held.
  assign stall    = stall_c & ~reset;
  assign misalign = misalign_c & ~reset;
  assign rd_valid = rd_valid_c & ~reset;
  assign dm_en    = dm_en_q;
  assign dm_we    = dm_we_q;
  assign dm_be    = be_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int unsigned LatA = 2;
  localparam int unsigned LatB = 1;
  localparam logic [31:0] Garbage = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata, dm_rdata;

  logic        a_stall, a_mis, a_en, a_we, a_rdv;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic        b_stall, b_mis, b_en, b_we, b_rdv;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rd;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DM_LAT(LatA)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(a_stall), .misalign(a_mis),
    .dm_en(a_en), .dm_we(a_we), .dm_be(a_be), .dm_addr(a_addr), .dm_wdata(a_wdata),
    .dm_rdata(dm_rdata), .rd_valid(a_rdv), .rd_data(a_rd)
  );

  mem_access_ctrl #(.DM_LAT(LatB)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(b_stall), .misalign(b_mis),
    .dm_en(b_en), .dm_we(b_we), .dm_be(b_be), .dm_addr(b_addr), .dm_wdata(b_wdata),
    .dm_rdata(dm_rdata), .rd_valid(b_rdv), .rd_data(b_rd)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs [NVec];

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero_a(input string name);
    chk({name, "_ctl"}, {23'd0, a_stall, a_mis, a_en, a_we, a_be, a_rdv}, 32'd0);
    chk({name, "_addr"}, a_addr, 32'd0);
    chk({name, "_wdata"}, a_wdata, 32'd0);
    chk({name, "_rd"}, a_rd, 32'd0);
  endtask

  // One request on DUT A; expects to be called just after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int stall_cnt = 0;
    int en_cnt = 0;
    int rdv_cnt = 0;
    int rdv_cyc = -1;
    logic [31:0] exp_addr;
    exp_addr  = {v.addr[31:2], 2'b00};
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    if (!v.exp_mis && !v.we) begin
      sb_q.push_back(v.exp_rd);
      last_rd = v.exp_rd;
    end
    for (int i = 0; i < int'(LatA) + 4; i++) begin
      dm_rdata = (i == int'(LatA)) ? v.rdata : Garbage;
      @(negedge clk);
      if (i == 0) begin
        chk($sformatf("v%0d_misalign", idx), {31'd0, a_mis}, {31'd0, v.exp_mis});
        chk($sformatf("v%0d_stall0", idx), {31'd0, a_stall}, {31'd0, !v.exp_mis});
      end
      if (a_stall) stall_cnt++;
      if (a_en) begin
        en_cnt++;
        chk($sformatf("v%0d_en_cycle", idx), i, 1);
        chk($sformatf("v%0d_dm_we", idx), {31'd0, a_we}, {31'd0, v.we});
      end
      if (!v.exp_mis && i >= 1 && i <= int'(LatA)) begin
        chk($sformatf("v%0d_dm_addr_c%0d", idx, i), a_addr, exp_addr);
        chk($sformatf("v%0d_dm_be_c%0d", idx, i), {28'd0, a_be}, {28'd0, v.exp_be});
        if (v.we) chk($sformatf("v%0d_dm_wdata_c%0d", idx, i), a_wdata, v.exp_wdata);
      end
      if (a_rdv) begin
        rdv_cnt++;
        rdv_cyc = i;
        if (sb_q.size() == 0) chk($sformatf("v%0d_unexpected_rd_valid", idx), 32'd1, 32'd0);
        else chk($sformatf("v%0d_rd_data", idx), a_rd, sb_q.pop_front());
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_mis ? 0 : int'(LatA) + 1);
    chk($sformatf("v%0d_en_count", idx), en_cnt, v.exp_mis ? 0 : 1);
    chk($sformatf("v%0d_rdv_count", idx), rdv_cnt, (v.exp_mis || v.we) ? 0 : 1);
    if (rdv_cnt != 0) chk($sformatf("v%0d_rdv_cycle", idx), rdv_cyc, int'(LatA) + 1);
    chk($sformatf("v%0d_sb_empty", idx), sb_q.size(), 0);
    if (v.we) chk($sformatf("v%0d_rd_hold", idx), a_rd, last_rd);
  endtask

  initial begin
    // we, size, addr, wdata, rdata, exp_rd, exp_be, exp_wdata, exp_mis
    vecs[0]  = '{1'b0, 3'b000, 32'h10, 32'h0, 32'h89ABCDEF, 32'h89ABCDEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 4'hF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 3'b011, 32'h12, 32'h0, 32'h80FF7F01, 32'h000080FF, 4'hF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 32'h11, 32'h0, 32'h80FF7F01, 32'h0000007F, 4'hF, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF7F01, 32'h00000080, 4'hF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h10, 32'h0, 32'h80FF7F01, 32'h00007F01, 4'hF, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h12, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 32'h6, 32'h123456AB, 32'h0, 32'h0, 4'b0100, 32'hABABABAB, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 32'h6, 32'h123456AB, 32'h0, 32'h0, 4'b1100, 32'h56AB56AB, 1'b0};
    vecs[9]  = '{1'b1, 3'b000, 32'h8, 32'h123456AB, 32'h0, 32'h0, 4'b1111, 32'h123456AB, 1'b0};
    vecs[10] = '{1'b1, 3'b001, 32'h4, 32'h123456AB, 32'h0, 32'h0, 4'b0011, 32'h56AB56AB, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 32'h2, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 3'b111, 32'h1, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b1};
    vecs[14] = '{1'b1, 3'b100, 32'h23, 32'h000000C5, 32'h0, 32'h0, 4'b1000, 32'hC5C5C5C5, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; dm_rdata = Garbage;
    #1;
    chk_all_zero_a("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < NVec; k++) run_vec(k, vecs[k]);

    // Reset in the second WAIT cycle of a load abandons it.
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'b000; req_addr = 32'h30;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero_a("rst_wait");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rdv_%0d", i), {30'd0, a_rdv, a_en}, 32'd0);
      if (i == 1) reset = 1'b0;
    end
    @(posedge clk);
    #1;
    run_vec(100, vecs[0]);

    // Back-to-back loads on the DM_LAT=1 instance with req_valid held through DONE.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    begin
      logic [6:0] exp_stall, exp_en, exp_rdv;
      int b_issues = 0;
      exp_stall = 7'b0011011;  // bit i = cycle i
      exp_en    = 7'b0010010;
      exp_rdv   = 7'b0100100;
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b000; req_addr = 32'h20;
      for (int i = 0; i < 7; i++) begin
        if (i == 3) req_addr = 32'h24;
        if (i == 6) req_valid = 1'b0;
        if (i == 1) dm_rdata = 32'h11111111;
        else if (i == 4) dm_rdata = 32'h22222222;
        else dm_rdata = Garbage;
        if (b_stall === 1'b0 && i == 0) sb_q.push_back(32'h11111111);
        if (i == 3) sb_q.push_back(32'h22222222);
        @(negedge clk);
        chk($sformatf("b2b_stall_c%0d", i), {31'd0, b_stall}, {31'd0, exp_stall[i]});
        chk($sformatf("b2b_en_c%0d", i), {31'd0, b_en}, {31'd0, exp_en[i]});
        chk($sformatf("b2b_rdv_c%0d", i), {31'd0, b_rdv}, {31'd0, exp_rdv[i]});
        if (b_en) begin
          b_issues++;
          chk($sformatf("b2b_addr_c%0d", i), b_addr, (i < 3) ? 32'h20 : 32'h24);
        end
        if (b_rdv) begin
          if (sb_q.size() == 0) chk("b2b_unexpected_rd_valid", 32'd1, 32'd0);
          else chk($sformatf("b2b_rd_data_c%0d", i), b_rd, sb_q.pop_front());
        end
        @(posedge clk);
        #1;
      end
      chk("b2b_issue_count", b_issues, 2);
      chk("b2b_sb_empty", sb_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
